// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
// Optional read path is controlled by SPI_REGFILE_READBACK_EN in the top level.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } spi_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchroniser with a previous-value flop for edge detection.
// The reset value is a parameter so idle-high inputs such as ncs start inactive.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W configuration registers.
// Define SPI_REGFILE_READBACK_EN to build the register readback path on cipo.
import spi_regfile_pkg::*;

module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  // state   | meaning
  // S_IDLE  | waiting for chip select
  // S_CMD   | receiving R/W and address
  // S_DATA  | receiving or sending the data field
  // S_HOLD  | frame complete, waiting for ncs to rise
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CMD  = ST_CMD;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_HOLD = ST_HOLD;

  localparam int FL       = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W    = $clog2(FL + 1);
  localparam int CMD_BITS = 1 + ADDR_W;

`ifdef SPI_REGFILE_READBACK_EN
  localparam logic READBACK = 1'b1;
`else
  localparam logic READBACK = 1'b0;
`endif

  logic sclk_level, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic copi_level, copi_rise, copi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [FL-1:0]     shift_q;
  logic [FL-1:0]     shift_nxt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              overrun_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic frame_full, addr_ok, do_commit, do_err;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign shift_nxt  = {shift_q[FL-2:0], copi_level};
  assign frame_full = (cnt_q == CNT_W'(FL)) && !overrun_q;
  assign addr_ok    = in_range(addr_q);
  assign do_commit  = frame_full && addr_ok && (rw_q == CMD_WRITE);
  // Out-of-range reads are only an error when there is a read path to serve them.
  assign do_err     = !frame_full || (!addr_ok && ((rw_q == CMD_WRITE) || READBACK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      rw_q      <= CMD_READ;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      // ncs rising takes priority over any sclk edge seen in the same cycle.
      if (ncs_rise) begin
        state_q <= S_IDLE;
        if (state_q != S_IDLE) begin
          frame_err <= do_err;
          if (do_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q == ADDR_W'(k)) begin
                regs[k]      <= shift_q[DATA_W-1:0];
                wr_strobe[k] <= 1'b1;
              end
            end
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ncs_fall) begin
              state_q   <= S_CMD;
              cnt_q     <= '0;
              shift_q   <= '0;
              rw_q      <= CMD_READ;
              addr_q    <= '0;
              overrun_q <= 1'b0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_inc;
              if (cnt_inc == CNT_W'(CMD_BITS)) begin
                state_q <= S_DATA;
                rw_q    <= shift_nxt[ADDR_W];
                addr_q  <= shift_nxt[ADDR_W-1:0];
              end
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_inc;
              if (cnt_inc == CNT_W'(FL)) state_q <= S_HOLD;
            end
          end
          default: begin
            if (sclk_rise) overrun_q <= 1'b1;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

`ifdef SPI_REGFILE_READBACK_EN
  logic              cmd_done;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift_q;
  logic              cipo_q;
  logic              is_read_q;

  assign cmd_done = !ncs_rise && (state_q == S_CMD) && sclk_rise &&
                    (cnt_inc == CNT_W'(CMD_BITS));

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (shift_nxt[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift_q <= '0;
      cipo_q     <= 1'b0;
      is_read_q  <= 1'b0;
    end else if (ncs_rise || ((state_q == S_IDLE) && ncs_fall)) begin
      cipo_q    <= 1'b0;
      is_read_q <= 1'b0;
    end else if (cmd_done) begin
      is_read_q  <= (shift_nxt[ADDR_W] == CMD_READ);
      rd_shift_q <= rd_word;
    end else if ((state_q == S_DATA) && sclk_fall && is_read_q) begin
      cipo_q     <= rd_shift_q[DATA_W-1];
      rd_shift_q <= {rd_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo_oe = is_read_q && ((state_q == S_DATA) || (state_q == S_HOLD));
  assign cipo    = cipo_oe & cipo_q;
`else
  assign cipo_oe = 1'b0;
  assign cipo    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: expected commits/errors are queued per frame.
// Readback expectations follow SPI_REGFILE_READBACK_EN.
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sclk, copi, ncs;
  logic                       cipo, cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic                       frame_err;

  spi_regfile_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .reg_q(reg_q),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REGS-1:0] strobe;
    logic                err;
    logic [DATA_W-1:0]   data;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [7:0]  mdl [NUM_REGS];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] mdl_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = mdl[k];
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_commit(input int idx, input logic [7:0] d);
    sb_item_t e;
    e.strobe = '0;
    e.strobe[idx] = 1'b1;
    e.err = 1'b0;
    e.data = d;
    sb_q.push_back(e);
    mdl[idx] = d;
  endtask

  task automatic push_err();
    sb_item_t e;
    e.strobe = '0;
    e.err = 1'b1;
    e.data = '0;
    sb_q.push_back(e);
  endtask

  // Shift n bits MSB first at clk/8; optionally check the readback data phase.
  task automatic shift_bits(input logic [31:0] bits, input int n,
                            input logic rd_chk, input logic [7:0] rd_data);
    for (int i = 0; i < n; i++) begin
      copi = bits[n-1-i];
      wait_clk(4);
      if (rd_chk) begin
`ifdef SPI_REGFILE_READBACK_EN
        if (i >= 8 && i < 16) begin
          check_val("cipo_bit", cipo, rd_data[15-i]);
          check_val("cipo_oe_data", cipo_oe, 1'b1);
        end else if (i < 8) begin
          check_val("cipo_oe_cmd", cipo_oe, 1'b0);
        end
`else
        check_val("cipo_off", cipo, 1'b0);
        check_val("cipo_oe_off", cipo_oe, 1'b0);
`endif
      end
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n,
                            input logic rd_chk, input logic [7:0] rd_data);
    ncs = 1'b0;
    wait_clk(6);
    shift_bits(bits, n, rd_chk, rd_data);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(12);
  endtask

  always @(negedge clk) begin
    if (!rst && (wr_strobe != '0 || frame_err)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", {wr_strobe, frame_err}, '0);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        check_val("wr_strobe", wr_strobe, e.strobe);
        check_val("frame_err", frame_err, e.err);
        for (int k = 0; k < NUM_REGS; k++)
          if (e.strobe[k]) check_val("commit_data", reg_q[k*DATA_W +: DATA_W], e.data);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
    wait_clk(4);
    check_val("rst_reg_q", reg_q, '0);
    check_val("rst_outs", {cipo, cipo_oe, wr_strobe, frame_err}, '0);
    rst = 1'b0;
    wait_clk(6);

    push_commit(2, 8'hA5);
    send_frame(32'h82A5, 16, 1'b0, 8'h00);
    check_val("reg_q_wr2", reg_q, mdl_flat());

    send_frame(32'h0200, 16, 1'b1, mdl[2]);
    check_val("reg_q_after_rd", reg_q, mdl_flat());

    push_err();
    send_frame(32'h8533, 16, 1'b0, 8'h00);
    check_val("reg_q_oor_wr", reg_q, mdl_flat());

    push_err();
    send_frame(32'h805, 12, 1'b0, 8'h00);
    push_err();
    send_frame(32'h8011 << 2, 18, 1'b0, 8'h00);
    check_val("reg_q_bad_len", reg_q, mdl_flat());

    // Reset in the middle of a write to register 1.
    ncs = 1'b0;
    wait_clk(6);
    shift_bits(32'h81AA >> 7, 9, 1'b0, 8'h00);
    rst = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
    wait_clk(2);
    check_val("midrst_reg_q", reg_q, '0);
    check_val("midrst_outs", {cipo, cipo_oe, wr_strobe, frame_err}, '0);
    ncs = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);

    push_commit(1, 8'h77);
    send_frame(32'h8177, 16, 1'b0, 8'h00);
    check_val("reg_q_wr1", reg_q, mdl_flat());

    send_frame(32'h0100, 16, 1'b1, mdl[1]);

    push_commit(4, 8'h3C);
    send_frame(32'h843C, 16, 1'b0, 8'h00);
    check_val("reg_q_wr4", reg_q, mdl_flat());

`ifdef SPI_REGFILE_READBACK_EN
    push_err();
`endif
    send_frame(32'h0600, 16, 1'b0, 8'h00);

    push_commit(0, 8'h5A);
    send_frame(32'h805A, 16, 1'b0, 8'h00);
    check_val("reg_q_wr0", reg_q, mdl_flat());

    send_frame(32'h0400, 16, 1'b1, mdl[4]);
    check_val("reg_q_final", reg_q, mdl_flat());

    wait_clk(10);
    check_val("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
